// File: rtl/gmii_tx_sched.sv
// GMII transmit scheduler: pulls length/timestamp-tagged frames from a 16-bit
// ring buffer and sends them with preamble, zero padding, CRC-32 and IFG.
module gmii_tx_sched (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tx_enable,
  input  logic [47:0] global_counter,
  input  logic [11:0] txmem_wr_ptr,
  output logic [11:0] txmem_rd_ptr,
  output logic [11:0] txmem_addr,
  input  logic [15:0] txmem_rdata,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic [31:0] tx_frames,
  output logic [15:0] tx_drops
);
  typedef enum logic [3:0] {
    IDLE, HDR, CHECK, WAIT_TS, PRE, DATA, PAD, FCS, IFG, DROP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] bcnt_q, bcnt_d;
  logic [11:0] len_q, len_d;
  logic [47:0] ts_q, ts_d;
  logic [11:0] nxt_q, nxt_d;
  logic        hdr_ok_q, hdr_ok_d;
  logic [31:0] crc_q, crc_d;
  logic [11:0] rd_ptr_q, rd_ptr_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic [31:0] frames_q, frames_d;
  logic [15:0] drops_q, drops_d;

  logic [11:0] need_w, avail_w, avail_nxt_w, end_ptr_w;
  logic        len_ok_w, ts_ok_w, fetch_w;
  logic [3:0]  hk_w;
  logic [7:0]  byte_w;
  logic [31:0] crc_fin_w;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign need_w      = 12'd4 + {1'b0, len_q[11:1]} + {11'd0, len_q[0]};
  assign avail_w     = txmem_wr_ptr - rd_ptr_q;
  assign avail_nxt_w = txmem_wr_ptr - nxt_q;
  assign end_ptr_w   = rd_ptr_q + need_w;
  assign len_ok_w    = (len_q >= 12'd14) && (len_q <= 12'd1514);
  assign ts_ok_w     = (ts_q == 48'd0) || (global_counter >= ts_q);
  assign byte_w      = bcnt_q[0] ? txmem_rdata[7:0] : txmem_rdata[15:8];
  assign crc_fin_w   = ~crc_q;
  // The next header is prefetched during IFG so back-to-back frames keep a 12-cycle gap.
  assign fetch_w     = (state_q == HDR) ||
                       ((state_q == IFG) && (cnt_q >= 4'd1) && (cnt_q <= 4'd5));
  assign hk_w        = (state_q == HDR) ? cnt_q : (cnt_q - 4'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    len_d    = len_q;
    ts_d     = ts_q;
    nxt_d    = nxt_q;
    hdr_ok_d = hdr_ok_q;
    crc_d    = crc_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    txd_d    = 8'h00;
    en_d     = 1'b0;
    frames_d = frames_q;
    drops_d  = drops_q;

    if (fetch_w) begin
      if (hk_w <= 4'd3) addr_d = addr_q + 12'd1;
      case (hk_w)
        4'd1:    len_d        = txmem_rdata[11:0];
        4'd2:    ts_d[47:32]  = txmem_rdata;
        4'd3:    ts_d[31:16]  = txmem_rdata;
        4'd4:    ts_d[15:0]   = txmem_rdata;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (tx_enable && (rd_ptr_q != txmem_wr_ptr)) begin
          state_d = HDR;
          cnt_d   = 4'd0;
          addr_d  = rd_ptr_q;
        end
      end
      HDR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd4) state_d = CHECK;
      end
      CHECK: begin
        if (!len_ok_w)              state_d = DROP;
        else if (avail_w >= need_w) state_d = WAIT_TS;
      end
      WAIT_TS: begin
        if (ts_ok_w) begin
          state_d = PRE;
          cnt_d   = 4'd0;
        end
      end
      PRE: begin
        en_d  = 1'b1;
        txd_d = (cnt_q == 4'd7) ? 8'hD5 : 8'h55;
        crc_d = 32'hFFFF_FFFF;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d = DATA;
          bcnt_d  = 12'd0;
        end
      end
      DATA: begin
        en_d   = 1'b1;
        txd_d  = byte_w;
        crc_d  = crc_byte(crc_q, byte_w);
        bcnt_d = bcnt_q + 12'd1;
        if (!bcnt_q[0]) addr_d = addr_q + 12'd1;
        if (bcnt_q == len_q - 12'd1) begin
          state_d = (len_q < 12'd60) ? PAD : FCS;
          cnt_d   = 4'd0;
        end
      end
      PAD: begin
        en_d   = 1'b1;
        crc_d  = crc_byte(crc_q, 8'h00);
        bcnt_d = bcnt_q + 12'd1;
        if (bcnt_q == 12'd59) begin
          state_d = FCS;
          cnt_d   = 4'd0;
        end
      end
      FCS: begin
        en_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    txd_d = crc_fin_w[7:0];
          2'd1:    txd_d = crc_fin_w[15:8];
          2'd2:    txd_d = crc_fin_w[23:16];
          default: txd_d = crc_fin_w[31:24];
        endcase
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd3) begin
          state_d = IFG;
          cnt_d   = 4'd0;
        end
      end
      IFG: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd0) begin
          nxt_d    = end_ptr_w;
          addr_d   = end_ptr_w;
          hdr_ok_d = (txmem_wr_ptr != end_ptr_w);
        end
        if (cnt_q == 4'd11) begin
          rd_ptr_d = nxt_q;
          frames_d = frames_q + 32'd1;
          cnt_d    = 4'd0;
          if (tx_enable && hdr_ok_q) begin
            if (len_ok_w && (avail_nxt_w >= need_w) && ts_ok_w) state_d = PRE;
            else                                                 state_d = CHECK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        rd_ptr_d = end_ptr_w;
        drops_d  = drops_q + 16'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      bcnt_q   <= 12'd0;
      len_q    <= 12'd0;
      ts_q     <= 48'd0;
      nxt_q    <= 12'd0;
      hdr_ok_q <= 1'b0;
      crc_q    <= 32'd0;
      rd_ptr_q <= 12'd0;
      addr_q   <= 12'd0;
      txd_q    <= 8'h00;
      en_q     <= 1'b0;
      frames_q <= 32'd0;
      drops_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      len_q    <= len_d;
      ts_q     <= ts_d;
      nxt_q    <= nxt_d;
      hdr_ok_q <= hdr_ok_d;
      crc_q    <= crc_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      txd_q    <= txd_d;
      en_q     <= en_d;
      frames_q <= frames_d;
      drops_q  <= drops_d;
    end
  end

  assign txmem_rd_ptr = rd_ptr_q;
  assign txmem_addr   = addr_q;
  assign gmii_txd     = txd_q;
  assign gmii_tx_en   = en_q;
  assign tx_frames    = frames_q;
  assign tx_drops     = drops_q;
endmodule

// File: doc/gmii_tx_sched.md
GMII_TX_SCHED -- requirements
Module: gmii_tx_sched

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: sys_clk  in  1  125 MHz clock, also the GMII transmit clock domain.
REQ-002 SHALL have: sys_rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have: tx_enable  in  1  1 = frames may start; 0 = hold in IDLE after the current frame completes.
REQ-004 SHALL have: global_counter  in  48  free-running timestamp time base.
REQ-005 SHALL have: txmem_wr_ptr  in  12  producer write pointer (word address) of the frame buffer.
REQ-006 SHALL have: txmem_rd_ptr  out  12  consumer read pointer; advanced only at frame boundaries.
REQ-007 SHALL have: txmem_addr  out  12  buffer read address.
REQ-008 SHALL have: txmem_rdata  in  16  buffer read data; 1-cycle read latency.
REQ-009 SHALL have: gmii_txd  out  8  GMII transmit data.
REQ-010 SHALL have: gmii_tx_en  out  1  GMII transmit enable.
REQ-011 SHALL have: tx_frames  out  32  count of frames sent.
REQ-012 SHALL have: tx_drops  out  16  count of frames discarded for bad length.

Function
REQ-013 SHALL treat the buffer as 4096 16-bit words; all address arithmetic is modulo 4096.
REQ-014 SHALL read the frame layout in this order:
- word0[11:0] = LEN, the byte count excluding FCS;
- words 1..3 = 48-bit TS, most-significant word first;
- then ceil(LEN/2) data words, high byte transmitted first; an odd LEN ignores the final low byte.
REQ-015 SHALL consider the buffer empty when txmem_rd_ptr == txmem_wr_ptr.
REQ-016 SHALL define avail as (txmem_wr_ptr - txmem_rd_ptr) mod 4096.
REQ-017 SHALL implement the states IDLE, HDR, CHECK, WAIT_TS, PRE, DATA, PAD, FCS, IFG, DROP.
REQ-018 SHALL transition IDLE->HDR when tx_enable=1 and the buffer is not empty.
REQ-019 SHALL in HDR read words 0..3, then go to CHECK.
REQ-020 SHALL in CHECK go to DROP if LEN<14 or LEN>1514.
REQ-021 SHALL in CHECK otherwise wait until avail >= 4+ceil(LEN/2), then go to WAIT_TS.
REQ-022 SHALL leave WAIT_TS for PRE when TS==0 or global_counter >= TS (unsigned compare).
REQ-023 SHALL in PRE emit seven 0x55 bytes then one 0xD5 byte, with gmii_tx_en=1.
REQ-024 SHALL in DATA emit LEN bytes, one per cycle, with no gap after the SFD.
REQ-025 SHALL in PAD emit 0x00 bytes until 60 bytes total (data+pad) when LEN<60.
REQ-026 SHALL in FCS emit CRC-32 over the data and pad bytes:
- polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final inversion;
- transmitted least-significant byte first.
REQ-027 SHALL hold gmii_tx_en=0 and gmii_txd=0x00 for exactly 12 cycles in IFG.
REQ-028 SHALL at the end of IFG update txmem_rd_ptr += 4+ceil(LEN/2), increment tx_frames, and return to IDLE.
REQ-029 SHALL in DROP, within 1 cycle, advance txmem_rd_ptr by 4+ceil(LEN/2), increment tx_drops, and go to IDLE, without asserting gmii_tx_en.
REQ-030 SHALL keep gmii_tx_en continuously high from the first preamble byte to the last FCS byte.
REQ-031 SHALL ignore txmem_wr_ptr changes for the frame in flight once it has left CHECK.
REQ-032 SHALL not abort a frame in flight when tx_enable is deasserted.
REQ-033 SHALL wrap tx_frames and tx_drops to 0 on overflow.
REQ-034 SHALL assert gmii_tx_en within 8 cycles of the WAIT_TS exit condition becoming true.

Reset
REQ-035 SHALL, while sys_rst_n=0 at a sys_clk edge, set the state to IDLE and clear txmem_rd_ptr, txmem_addr, gmii_txd, gmii_tx_en, tx_frames, tx_drops and the CRC state to 0.
REQ-036 SHALL, when reset is asserted mid-frame, take gmii_tx_en low on the next cycle and discard the partial frame without updating any counters.

Verification
REQ-037 SHALL cover reset: hold sys_rst_n=0 for 2 cycles -> all outputs 0; buffer with wr_ptr=0 -> gmii_tx_en stays 0.
REQ-038 SHALL cover a basic frame: LEN=60, TS=0 at word 0, wr_ptr=0x022 -> gmii_tx_en high for 72 consecutive cycles (55x7, D5, 60 data bytes, FCS matching the software CRC-32); rd_ptr=0x022; tx_frames=1.
REQ-039 SHALL cover timestamp hold: TS=0x2000 with global_counter=0x1F00 counting up -> no gmii_tx_en before global_counter=0x2000; assertion within 8 cycles after it.
REQ-040 SHALL cover padding: LEN=42 -> 42 data bytes, 18 bytes of 0x00, FCS computed over 60 bytes; rd_ptr advances by 25.
REQ-041 SHALL cover wrap-around: frame at rd_ptr=0xFF0 with LEN=60 -> correct byte sequence across address 0xFFF->0x000; final rd_ptr=0x012.
REQ-042 SHALL cover back-to-back frames and a drop: two LEN=60 frames -> exactly 12 idle cycles between them; then LEN=2000 -> no transmission, tx_drops=1, rd_ptr advanced by 1004 mod 4096.
